// File: rtl/cpri_align_pkg.sv
// Shared types and sizing for the CPRI chip aligner.
// Holds the sop-tracker state enum, the default chip geometry and counter widths.
package cpri_align_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  localparam int unsigned CHIP_LEN_DEF      = 96;
  localparam int unsigned CHIPS_PER_SYM_DEF = 132;

  localparam int unsigned WCNT_W  = 7;
  localparam int unsigned MISS_W  = 2;
  localparam int unsigned CHIP_W  = 8;
  localparam int unsigned ERR_W   = 16;
  localparam int unsigned N_LANES = 8;

endpackage

// File: rtl/cpri_sop_tracker.sv
// Chip-boundary tracker: HUNT/VERIFY/LOCKED FSM, word counter and miss counter.
// Ports:
//   clk, rst          clock, async active-low reset
//   i_sop             chip start marker (word 0)
//   o_word_c          word index of the current cycle (0 on any sop)
//   o_vld_c           current cycle carries an aligned word
//   o_enter_lock_c    current cycle is the VERIFY->LOCKED sop (word 0 of chip 0)
//   o_err_c           unexpected sop or lock loss in the current cycle
//   o_locked          FSM state is LOCKED
module cpri_sop_tracker
  import cpri_align_pkg::*;
#(
  parameter int unsigned CHIP_LEN = CHIP_LEN_DEF,
  parameter int unsigned MISS_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sop,
  output logic [WCNT_W-1:0] o_word_c,
  output logic              o_vld_c,
  output logic              o_enter_lock_c,
  output logic              o_err_c,
  output logic              o_locked
);

  if (CHIP_LEN > 128 || CHIP_LEN < 2) begin : g_bad_chip_len
    $error("CHIP_LEN must be in 2..128");
  end
  if (MISS_MAX < 1 || MISS_MAX > 3) begin : g_bad_miss_max
    $error("MISS_MAX must be in 1..3");
  end

  align_state_e      r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [MISS_W-1:0] r_miss;

  logic w_at_end;
  logic w_miss_last;

  // r_wcnt holds the previous cycle's word index; at_end means this cycle is a natural word 0
  assign w_at_end    = (r_wcnt == WCNT_W'(CHIP_LEN - 1));
  assign w_miss_last = (r_miss == MISS_W'(MISS_MAX - 1));

  assign o_word_c       = (i_sop || w_at_end) ? '0 : r_wcnt + WCNT_W'(1);
  assign o_enter_lock_c = (r_state == ST_VERIFY) && i_sop && w_at_end;
  assign o_vld_c        = (r_state == ST_LOCKED) || o_enter_lock_c;
  assign o_err_c        = (r_state == ST_LOCKED) &&
                          ((i_sop && !w_at_end) || (!i_sop && w_at_end && w_miss_last));
  assign o_locked       = (r_state == ST_LOCKED);

  // State, word counter and miss counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_HUNT;
      r_wcnt  <= '0;
      r_miss  <= '0;
    end else begin
      r_wcnt <= o_word_c;
      unique case (r_state)
        ST_HUNT: begin
          if (i_sop) r_state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          r_miss <= '0;
          if (i_sop && w_at_end)       r_state <= ST_LOCKED;
          else if (!i_sop && w_at_end) r_state <= ST_HUNT;
        end
        ST_LOCKED: begin
          // a sop always wins over a coincident miss evaluation
          if (i_sop) begin
            r_miss <= '0;
            if (!w_at_end) r_state <= ST_VERIFY;
          end else if (w_at_end) begin
            if (w_miss_last) begin
              r_state <= ST_HUNT;
              r_miss  <= '0;
            end else begin
              r_miss <= r_miss + MISS_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_HUNT;
          r_miss  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpri_chip_aligner.sv
// CPRI chip aligner: locks to the periodic chip sop, flywheels over missing sops and
// presents 8 lanes of aligned data with word/chip indices one cycle after input.
// Ports:
//   clk, rst                        clock, async active-low reset
//   sop_cpri_i                      chip start marker
//   dat_cpri0_i..dat_cpri7_i        lane data, valid every cycle
//   vld_o, dat0_o..dat7_o           aligned data (zeroed when not valid)
//   word_idx_o, chip_idx_o          position within chip / symbol
//   sym_sop_o                       word 0 of chip 0
//   locked_o, err_o, err_cnt_o      lock status, error pulse, saturating error count
module cpri_chip_aligner
  import cpri_align_pkg::*;
#(
  parameter int unsigned DAT_DW        = 64,
  parameter int unsigned CHIP_LEN      = CHIP_LEN_DEF,
  parameter int unsigned CHIPS_PER_SYM = CHIPS_PER_SYM_DEF,
  parameter int unsigned MISS_MAX      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sop_cpri_i,
  input  logic [DAT_DW-1:0] dat_cpri0_i,
  input  logic [DAT_DW-1:0] dat_cpri1_i,
  input  logic [DAT_DW-1:0] dat_cpri2_i,
  input  logic [DAT_DW-1:0] dat_cpri3_i,
  input  logic [DAT_DW-1:0] dat_cpri4_i,
  input  logic [DAT_DW-1:0] dat_cpri5_i,
  input  logic [DAT_DW-1:0] dat_cpri6_i,
  input  logic [DAT_DW-1:0] dat_cpri7_i,
  output logic              vld_o,
  output logic [DAT_DW-1:0] dat0_o,
  output logic [DAT_DW-1:0] dat1_o,
  output logic [DAT_DW-1:0] dat2_o,
  output logic [DAT_DW-1:0] dat3_o,
  output logic [DAT_DW-1:0] dat4_o,
  output logic [DAT_DW-1:0] dat5_o,
  output logic [DAT_DW-1:0] dat6_o,
  output logic [DAT_DW-1:0] dat7_o,
  output logic [WCNT_W-1:0] word_idx_o,
  output logic [CHIP_W-1:0] chip_idx_o,
  output logic              sym_sop_o,
  output logic              locked_o,
  output logic              err_o,
  output logic [ERR_W-1:0]  err_cnt_o
);

  if (CHIPS_PER_SYM > 256 || CHIPS_PER_SYM < 1) begin : g_bad_chips_per_sym
    $error("CHIPS_PER_SYM must be in 1..256");
  end

  logic [WCNT_W-1:0] w_word_c;
  logic              w_vld_c;
  logic              w_enter_lock_c;
  logic              w_err_c;
  logic [CHIP_W-1:0] w_chip_c;
  logic [CHIP_W-1:0] w_chip_inc;
  logic [CHIP_W-1:0] r_chip;
  logic [DAT_DW-1:0] w_dat_in [N_LANES];
  logic [DAT_DW-1:0] r_dat    [N_LANES];

  cpri_sop_tracker #(
    .CHIP_LEN (CHIP_LEN),
    .MISS_MAX (MISS_MAX)
  ) u_tracker (
    .clk            (clk),
    .rst            (rst),
    .i_sop          (sop_cpri_i),
    .o_word_c       (w_word_c),
    .o_vld_c        (w_vld_c),
    .o_enter_lock_c (w_enter_lock_c),
    .o_err_c        (w_err_c),
    .o_locked       (locked_o)
  );

  assign w_dat_in[0] = dat_cpri0_i;
  assign w_dat_in[1] = dat_cpri1_i;
  assign w_dat_in[2] = dat_cpri2_i;
  assign w_dat_in[3] = dat_cpri3_i;
  assign w_dat_in[4] = dat_cpri4_i;
  assign w_dat_in[5] = dat_cpri5_i;
  assign w_dat_in[6] = dat_cpri6_i;
  assign w_dat_in[7] = dat_cpri7_i;

  assign dat0_o = r_dat[0];
  assign dat1_o = r_dat[1];
  assign dat2_o = r_dat[2];
  assign dat3_o = r_dat[3];
  assign dat4_o = r_dat[4];
  assign dat5_o = r_dat[5];
  assign dat6_o = r_dat[6];
  assign dat7_o = r_dat[7];

  // Chip index of the current cycle: restarts at lock entry, advances on every valid word 0
  assign w_chip_inc = (r_chip == CHIP_W'(CHIPS_PER_SYM - 1)) ? '0 : r_chip + CHIP_W'(1);

  always_comb begin
    w_chip_c = r_chip;
    if (w_enter_lock_c)                      w_chip_c = '0;
    else if (w_vld_c && (w_word_c == '0))    w_chip_c = w_chip_inc;
  end

  // Output pipeline stage, chip counter and error counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chip     <= '0;
      vld_o      <= 1'b0;
      word_idx_o <= '0;
      chip_idx_o <= '0;
      sym_sop_o  <= 1'b0;
      err_o      <= 1'b0;
      err_cnt_o  <= '0;
      for (int k = 0; k < N_LANES; k++) r_dat[k] <= '0;
    end else begin
      r_chip     <= w_chip_c;
      vld_o      <= w_vld_c;
      word_idx_o <= w_vld_c ? w_word_c : '0;
      chip_idx_o <= w_vld_c ? w_chip_c : '0;
      sym_sop_o  <= w_vld_c && (w_word_c == '0) && (w_chip_c == '0);
      err_o      <= w_err_c;
      if (w_err_c && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + ERR_W'(1);
      for (int k = 0; k < N_LANES; k++) r_dat[k] <= w_vld_c ? w_dat_in[k] : '0;
    end
  end

endmodule

// File: doc/cpri_chip_aligner.md
CPRI_CHIP_ALIGNER -- requirements
Module: cpri_chip_aligner

Interface
REQ-001 Parameter DAT_DW, default 64: width of each CPRI lane word.
REQ-002 Parameter CHIP_LEN, default 96: clock cycles per chip, i.e. the sop period.
REQ-003 Parameter CHIPS_PER_SYM, default 132: chips per symbol.
REQ-004 Parameter MISS_MAX, default 3: consecutive missing sops tolerated while LOCKED.
REQ-005 Port clk, input, 1: sole clock.
REQ-006 Port rst, input, 1: reset, asynchronous, active-low.
REQ-007 Port sop_cpri_i, input, 1: chip start marker; the sop cycle carries word 0.
REQ-008 Ports dat_cpri0_i..dat_cpri7_i, input, DAT_DW each: lane data, valid every cycle.
REQ-009 Port vld_o, output, 1: aligned word valid.
REQ-010 Ports dat0_o..dat7_o, output, DAT_DW each: aligned lane data.
REQ-011 Port word_idx_o, output, 7: word index within the chip, 0..CHIP_LEN-1.
REQ-012 Port chip_idx_o, output, 8: chip index within the symbol, 0..CHIPS_PER_SYM-1.
REQ-013 Port sym_sop_o, output, 1: pulse on word 0 of chip 0.
REQ-014 Port locked_o, output, 1: FSM is in LOCKED.
REQ-015 Port err_o, output, 1: one-cycle pulse on an unexpected sop or on lock loss.
REQ-016 Port err_cnt_o, output, 16: error count, saturates at 0xFFFF.

Function
REQ-017 The FSM SHALL have exactly three states: HUNT, VERIFY and LOCKED.
REQ-018 A free word counter wcnt SHALL load 0 on any accepted sop; otherwise it increments and wraps from CHIP_LEN-1 to 0.
REQ-019 HUNT, on sop: go to VERIFY with wcnt=0; all other cycles: hold.
REQ-020 VERIFY: sop at wcnt==CHIP_LEN-1 goes to LOCKED; sop at any other wcnt restarts VERIFY with wcnt=0 and no err; no sop by the wrap goes to HUNT.
REQ-021 LOCKED: sop at wcnt==CHIP_LEN-1 (expected) clears the miss counter.
REQ-022 LOCKED: no sop at the expected cycle increments the miss counter and flywheels (wcnt wraps, output continues).
REQ-023 LOCKED: miss counter reaching MISS_MAX goes to HUNT with an err_o pulse.
REQ-024 LOCKED: an unexpected sop (wcnt != CHIP_LEN-1) pulses err_o and goes to VERIFY with wcnt=0; vld_o drops from the following cycle.
REQ-025 In all states, err_cnt_o SHALL increment on every err_o pulse and saturate at 0xFFFF.
REQ-026 Output latency SHALL be exactly 1 cycle: outputs at cycle n+1 reflect inputs and state at cycle n.
REQ-027 vld_o SHALL be high iff the FSM was LOCKED at cycle n, or at cycle n the FSM transitions VERIFY->LOCKED (that sop cycle is word 0).
REQ-028 When vld_o=0, dat*_o, word_idx_o, chip_idx_o and sym_sop_o SHALL be 0.
REQ-029 word_idx_o SHALL equal the wcnt value of cycle n.
REQ-030 chip_idx_o SHALL be 0 on the first chip after entering LOCKED and increment at each word 0, wrapping from CHIPS_PER_SYM-1 to 0; flywheeled chips also count.
REQ-031 sym_sop_o = vld_o AND word_idx_o==0 AND chip_idx_o==0.
REQ-032 When a sop coincides with the MISS_MAX-th miss evaluation, the sop SHALL win: it is either the expected sop or unexpected-sop handling (REQ-024).
REQ-033 Counter widths SHALL be wcnt 7 bits, miss counter 2 bits and chip counter 8 bits; elaboration SHALL fail if CHIP_LEN>128 or CHIPS_PER_SYM>256.

Reset
REQ-034 Asserting rst (low) SHALL immediately force the FSM to HUNT, wcnt, miss and chip counters to 0, all outputs to 0, and err_cnt_o to 0.
REQ-035 Reset asserted mid-chip SHALL discard the partial chip; after release, the first sop begins VERIFY.
REQ-036 Reset SHALL be released synchronously to clk outside this block.

Structure
REQ-037 Package cpri_align_pkg SHALL hold the FSM state enum and the CHIP_LEN/CHIPS_PER_SYM defaults.
REQ-038 Sub-module cpri_sop_tracker SHALL contain the FSM, wcnt and miss counter.
REQ-039 The top level SHALL contain the data pipeline registers, the chip counter and the error counter.

Verification
REQ-040 Clean lock: sop every 96 cycles from t=10 -> locked_o rises at t=107; vld_o rises at t=107 with word_idx_o=0 and chip_idx_o=0; sym_sop_o=1 once.
REQ-041 Symbol wrap: 140 periodic chips after lock -> chip_idx_o sequence 0..131, 0..7; sym_sop_o pulses exactly twice; err_cnt_o=0.
REQ-042 Flywheel: drop 2 sops while locked -> locked_o stays 1, word_idx_o continuity holds, err_o=0; drop 3 consecutive sops -> HUNT, err_o pulses once, err_cnt_o=1.
REQ-043 Unexpected sop: sop at wcnt=40 while locked -> err_o pulses, vld_o=0 from the next cycle, relock 96 cycles later with chip_idx_o=0.
REQ-044 Data alignment: lane k input = {k, chip#, word#} -> dat k output matches with 1-cycle latency and correct word_idx_o on all 8 lanes.
REQ-045 Reset mid-operation: rst low at word 50 while locked -> all outputs 0 immediately; after release, periodic sops relock after 96 cycles.
